wb_qcw_ramp: RTL and testbench
==============================

Name: wb_qcw_ramp

Overview:
- Wishbone slave on the SoC external bus (wb_adr/wb_dat/wb_sel/wb_we/wb_stb/wb_cyc) that generates the QCW power-ramp envelope for the bridge driver.
- Firmware writes ramp start/end levels, step rate, hold time and cooldown, then fires START.
- The block sequences RAMP -> HOLD -> COOL autonomously and drives a level setpoint plus a drive-enable.
- An external fault input aborts any cycle immediately.

Parameters:
- BASE_ADR, 32'h03000000: bus window base; block decodes 32 bytes (adr[31:5]).
- LVL_W, 12: width of levels and of ramp_o.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_ni  in  1  synchronous active-low reset.
- wb_adr_i  in  32  byte address.
- wb_dat_i  in  32  write data.
- wb_sel_i  in  4  byte enables.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  acknowledge.
- wb_dat_o  out  32  read data; zero whenever ack is low (bus is OR-combined).
- fault_i  in  1  bridge fault, level sensitive.
- ramp_o  out  LVL_W  power setpoint.
- drive_en_o  out  1  bridge enable.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset state:
  - All registers 0, FSM in IDLE.
  - wb_ack_o=0, wb_dat_o=0, ramp_o=0, drive_en_o=0.
- Bus access:
  - Select = cyc & stb & (adr[31:5]==BASE_ADR[31:5]) & !ack.
  - ack is registered: high the cycle after select, exactly 1 cycle. Back-to-back accesses therefore take 2 cycles each.
  - Reads return data in the ack cycle.
  - Writes commit on the ack cycle, honouring sel per byte.
  - Unmapped offsets inside the window: ack, read 0, write ignored.
- Register map (offset = adr[4:2]*4):
  - 0x00 CTRL: wr bit0 START (pulse), wr bit1 ABORT (pulse), rd bit2 BUSY, bit3 DONE (sticky, write 1 to clear), bit4 FAULT (sticky, write 1 to clear).
  - 0x04 START_LVL [LVL_W-1:0].
  - 0x08 END_LVL [LVL_W-1:0].
  - 0x0C STEP_DIV [15:0].
  - 0x10 HOLD_CYC [23:0].
  - 0x14 COOL_CYC [23:0].
  - 0x18 LEVEL (RO, current level).
- FSM states: IDLE, RAMP, HOLD, COOL.
- IDLE:
  - START write -> RAMP next cycle.
  - level := START_LVL, step counter := 0.
  - START while not IDLE is ignored.
- RAMP:
  - Step counter counts 0..STEP_DIV. At STEP_DIV it ticks and resets, so each level persists STEP_DIV+1 cycles.
  - On tick: if level<END_LVL, level+1; else -> HOLD with counter := HOLD_CYC.
  - START_LVL>=END_LVL: holds at START_LVL for one step, then HOLD. Level never decrements.
- HOLD: lasts HOLD_CYC+1 cycles at the final level, then -> COOL with counter := COOL_CYC.
- COOL:
  - drive_en_o=0, ramp_o=0.
  - Lasts COOL_CYC+1 cycles, then -> IDLE and DONE:=1.
- Outputs:
  - drive_en_o=1 and ramp_o=level in RAMP and HOLD only. Both are registered, updated on the same edge as the state.
  - BUSY = state!=IDLE.
- Abort and fault:
  - ABORT write or fault_i=1 in RAMP/HOLD -> COOL next cycle; drive_en_o drops on that edge.
  - fault_i additionally sets FAULT.
  - fault_i in COOL keeps setting FAULT and does not restart COOL.
  - DONE is still set at COOL exit.
- Simultaneous events:
  - fault_i in IDLE with a START write: START ignored, FAULT set.
  - Config writes during a run take effect live: the new END_LVL is compared on the next tick, and HOLD_CYC/COOL_CYC are sampled only on state entry.
  - Same-cycle W1C and set of DONE/FAULT: set wins.
- Reset mid-run: returns to IDLE immediately, outputs 0, config registers cleared.

Optional Feature:
- Macro: QCW_RAMP_IRQ_EN.
- When defined:
  - Adds port irq_o (out, 1).
  - CTRL bit8 IRQ_EN is read/write, reset value 0.
  - irq_o = IRQ_EN & (DONE | FAULT), registered.
- When undefined: no irq_o port; CTRL bit8 reads 0 and writes to it are ignored.

Test Plan:
- Bus handshake: write 0x0C=0x1234, then read it back -> ack exactly 1 cycle per access; read 0x00001234; wb_dat_o=0 outside the ack cycle; read offset 0x1C -> 0.
- Nominal run (START=10, END=13, STEP_DIV=1, HOLD=4, COOL=2, then write CTRL=1):
  - ramp_o 10,10,11,11,12,12,13,13, then 5 cycles at 13, with drive_en_o high for 13 cycles.
  - 3 cycles of COOL with outputs 0; BUSY high for 16 cycles; DONE=1.
- Degenerate and ignored START: START=20, END=5, STEP_DIV=0, HOLD=0 -> 1 cycle at 20, 1 HOLD cycle at 20, then COOL. A second START during the run has no effect.
- Fault: assert fault_i for 1 cycle mid-RAMP at level 11 -> drive_en_o=0 and ramp_o=0 next edge; FAULT=1; COOL runs COOL_CYC+1 cycles; DONE=1. Writing 0x18 to CTRL clears both flags.
- Reset: drive wb_rst_ni low for 1 cycle during HOLD -> next edge all outputs 0, all registers read 0, BUSY=0.
- IRQ (QCW_RAMP_IRQ_EN only): IRQ_EN=1 with a nominal run -> irq_o rises 1 cycle after DONE sets and falls after DONE is cleared with W1C.

Source files
------------

// File: rtl/wb_qcw_ramp.sv
`default_nettype none
// ============================================================================
// Module   : wb_qcw_ramp
// Purpose  : Wishbone slave that generates the QCW power-ramp envelope for the
//            bridge driver. Firmware programs start/end levels, the step
//            divider, the hold time and the cooldown, then fires START. The
//            block runs RAMP -> HOLD -> COOL on its own and drives a level
//            setpoint plus a drive enable. A fault input aborts any cycle.
// Ports    : wb_clk_i / wb_rst_ni     clock, synchronous active-low reset
//            wb_adr_i/dat_i/sel_i/we_i/cyc_i/stb_i   Wishbone request
//            wb_ack_o / wb_dat_o      registered ack, read data (0 w/o ack)
//            fault_i                  bridge fault, level sensitive
//            ramp_o                   power setpoint (0 outside RAMP/HOLD)
//            drive_en_o               bridge enable (RAMP/HOLD only)
//            irq_o                    present only with QCW_RAMP_IRQ_EN
// Options  : `define QCW_RAMP_IRQ_EN adds irq_o and the CTRL[8] IRQ_EN bit.
// Revision : 1.0 - initial release
// ============================================================================
module wb_qcw_ramp #(
    parameter logic [31:0] BASE_ADR = 32'h0300_0000,
    parameter int          LVL_W    = 12
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic             wb_ack_o,
    output logic [31:0]      wb_dat_o,
    input  logic             fault_i,
    output logic [LVL_W-1:0] ramp_o,
`ifdef QCW_RAMP_IRQ_EN
    output logic             irq_o,
`endif
    output logic             drive_en_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RAMP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_COOL = 2'd3;

    localparam logic [2:0] c_off_ctrl  = 3'd0;
    localparam logic [2:0] c_off_start = 3'd1;
    localparam logic [2:0] c_off_end   = 3'd2;
    localparam logic [2:0] c_off_step  = 3'd3;
    localparam logic [2:0] c_off_hold  = 3'd4;
    localparam logic [2:0] c_off_cool  = 3'd5;
    localparam logic [2:0] c_off_level = 3'd6;

    logic [1:0]       r_state;
    logic [23:0]      r_cnt;
    logic [LVL_W-1:0] r_level;
    logic [LVL_W-1:0] r_start_lvl;
    logic [LVL_W-1:0] r_end_lvl;
    logic [15:0]      r_step_div;
    logic [23:0]      r_hold_cyc;
    logic [23:0]      r_cool_cyc;
    logic             r_done;
    logic             r_fault;
    logic             r_ack;
    logic [31:0]      r_rdata;
    logic [LVL_W-1:0] r_ramp;
    logic             r_drive_en;

    logic [1:0]       w_state_nxt;
    logic [23:0]      w_cnt_nxt;
    logic [LVL_W-1:0] w_level_nxt;
    logic             w_done_set;
    logic             w_drive_nxt;
    logic [LVL_W-1:0] w_ramp_nxt;

    logic             w_sel;
    logic             w_wr;
    logic [2:0]       w_off;
    logic [23:0]      w_mask;
    logic             w_ctrl_wr;
    logic             w_start;
    logic             w_abort;
    logic             w_clr_done;
    logic             w_clr_fault;
    logic             w_busy;
    logic             w_irq_en;
    logic [31:0]      w_rd_mux;
    logic             w_unused_ok;

    // ------------------------------------------------------------------
    // Bus decode. The !ack term keeps a held strobe from re-selecting in
    // the ack cycle, so every access costs two cycles. Writes commit on
    // the same edge that raises ack, so the ack cycle already sees them.
    // ------------------------------------------------------------------
    assign w_sel = wb_cyc_i & wb_stb_i & (wb_adr_i[31:5] == BASE_ADR[31:5]) & ~r_ack;
    assign w_wr  = w_sel & wb_we_i;
    assign w_off = wb_adr_i[4:2];

    // Byte-lane mask; no writable register is wider than 24 bits.
    assign w_mask = {{8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

    assign w_ctrl_wr   = w_wr & (w_off == c_off_ctrl) & wb_sel_i[0];
    assign w_start     = w_ctrl_wr & wb_dat_i[0];
    assign w_abort     = w_ctrl_wr & wb_dat_i[1];
    assign w_clr_done  = w_ctrl_wr & wb_dat_i[3];
    assign w_clr_fault = w_ctrl_wr & wb_dat_i[4];
    assign w_busy      = (r_state != S_IDLE);

    assign w_unused_ok = ^{wb_adr_i[1:0], wb_dat_i[31:24], wb_sel_i[3]};

`ifdef QCW_RAMP_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && (w_off == c_off_ctrl) && wb_sel_i[1]) begin
                r_irq_en <= wb_dat_i[8];
            end
            r_irq <= r_irq_en & (r_done | r_fault);
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq_o    = r_irq;
`else
    assign w_irq_en = 1'b0;
`endif

    // Read mux, sampled in the select cycle and presented during ack.
    always_comb begin
        w_rd_mux = '0;
        case (w_off)
            c_off_ctrl:  w_rd_mux = {23'd0, w_irq_en, 3'd0, r_fault, r_done, w_busy, 2'd0};
            c_off_start: w_rd_mux[LVL_W-1:0] = r_start_lvl;
            c_off_end:   w_rd_mux[LVL_W-1:0] = r_end_lvl;
            c_off_step:  w_rd_mux[15:0] = r_step_div;
            c_off_hold:  w_rd_mux[23:0] = r_hold_cyc;
            c_off_cool:  w_rd_mux[23:0] = r_cool_cyc;
            c_off_level: w_rd_mux[LVL_W-1:0] = r_level;
            default:     w_rd_mux = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Bus, configuration and status registers
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_ack       <= 1'b0;
            r_rdata     <= '0;
            r_start_lvl <= '0;
            r_end_lvl   <= '0;
            r_step_div  <= '0;
            r_hold_cyc  <= '0;
            r_cool_cyc  <= '0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_ack   <= w_sel;
            r_rdata <= (w_sel && !wb_we_i) ? w_rd_mux : '0;
            if (w_wr && w_off == c_off_start) begin
                r_start_lvl <= (r_start_lvl & ~w_mask[LVL_W-1:0]) | (wb_dat_i[LVL_W-1:0] & w_mask[LVL_W-1:0]);
            end
            if (w_wr && w_off == c_off_end) begin
                r_end_lvl <= (r_end_lvl & ~w_mask[LVL_W-1:0]) | (wb_dat_i[LVL_W-1:0] & w_mask[LVL_W-1:0]);
            end
            if (w_wr && w_off == c_off_step) begin
                r_step_div <= (r_step_div & ~w_mask[15:0]) | (wb_dat_i[15:0] & w_mask[15:0]);
            end
            if (w_wr && w_off == c_off_hold) begin
                r_hold_cyc <= (r_hold_cyc & ~w_mask) | (wb_dat_i[23:0] & w_mask);
            end
            if (w_wr && w_off == c_off_cool) begin
                r_cool_cyc <= (r_cool_cyc & ~w_mask) | (wb_dat_i[23:0] & w_mask);
            end
            // Set beats write-1-to-clear in the same cycle.
            r_done  <= w_done_set | (r_done & ~w_clr_done);
            r_fault <= fault_i | (r_fault & ~w_clr_fault);
        end
    end

    // ------------------------------------------------------------------
    // FSM: state register (with datapath and registered outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_level    <= '0;
            r_ramp     <= '0;
            r_drive_en <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_level    <= w_level_nxt;
            r_ramp     <= w_ramp_nxt;
            r_drive_en <= w_drive_nxt;
        end
    end

    // FSM: next-state logic. r_cnt is the step counter in RAMP (counting
    // up to STEP_DIV) and a down-counter in HOLD and COOL, loaded on entry.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_done_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A fault in the same cycle vetoes START.
                if (w_start && !fault_i) begin
                    w_state_nxt = S_RAMP;
                    w_level_nxt = r_start_lvl;
                    w_cnt_nxt   = '0;
                end
            end
            S_RAMP: begin
                if (w_abort || fault_i) begin
                    w_state_nxt = S_COOL;
                    w_cnt_nxt   = r_cool_cyc;
                end else if (r_cnt[15:0] == r_step_div) begin
                    // END_LVL is compared live, so a mid-run rewrite applies
                    // on the next tick. The level only ever climbs.
                    if (r_level < r_end_lvl) begin
                        w_level_nxt = r_level + LVL_W'(1);
                        w_cnt_nxt   = '0;
                    end else begin
                        w_state_nxt = S_HOLD;
                        w_cnt_nxt   = r_hold_cyc;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 24'd1;
                end
            end
            S_HOLD: begin
                if (w_abort || fault_i || r_cnt == 24'd0) begin
                    w_state_nxt = S_COOL;
                    w_cnt_nxt   = r_cool_cyc;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            S_COOL: begin
                // Faults here only latch FAULT; the cooldown is not restarted.
                if (r_cnt == 24'd0) begin
                    w_state_nxt = S_IDLE;
                    w_done_set  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // FSM: output logic, computed from the next state so the registered
    // outputs change on the same edge as the state.
    always_comb begin
        w_drive_nxt = (w_state_nxt == S_RAMP) || (w_state_nxt == S_HOLD);
        w_ramp_nxt  = w_drive_nxt ? w_level_nxt : '0;
    end

    assign wb_ack_o   = r_ack;
    assign wb_dat_o   = r_rdata;
    assign ramp_o     = r_ramp;
    assign drive_en_o = r_drive_en;

endmodule
`default_nettype wire

// File: tb/tb_wb_qcw_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_qcw_ramp
// Purpose  : Self-checking bench for wb_qcw_ramp. Expected envelope samples
//            ({drive_en, ramp}) are queued before each run and compared cycle
//            by cycle once the bridge enable rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_qcw_ramp;

    localparam logic [31:0] BASE   = 32'h0300_0000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_STRT = BASE + 32'h04;
    localparam logic [31:0] A_END  = BASE + 32'h08;
    localparam logic [31:0] A_STEP = BASE + 32'h0C;
    localparam logic [31:0] A_HOLD = BASE + 32'h10;
    localparam logic [31:0] A_COOL = BASE + 32'h14;
    localparam logic [31:0] A_LVL  = BASE + 32'h18;
`ifdef QCW_RAMP_IRQ_EN
    localparam logic [31:0] c_irq_bit = 32'h100;
`else
    localparam logic [31:0] c_irq_bit = 32'h0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] wb_adr = '0;
    logic [31:0] wb_dat = '0;
    logic [3:0]  wb_sel = '0;
    logic        wb_we = 1'b0;
    logic        wb_cyc = 1'b0;
    logic        wb_stb = 1'b0;
    logic        wb_ack;
    logic [31:0] wb_dat_o;
    logic        fault = 1'b0;
    logic [11:0] ramp;
    logic        drive_en;
`ifdef QCW_RAMP_IRQ_EN
    logic        irq;
`endif

    int n_total = 0;
    int n_bad   = 0;
    logic [12:0] sb[$];

    always #5 clk = ~clk;

    wb_qcw_ramp #(.BASE_ADR(BASE), .LVL_W(12)) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .wb_adr_i   (wb_adr),
        .wb_dat_i   (wb_dat),
        .wb_sel_i   (wb_sel),
        .wb_we_i    (wb_we),
        .wb_cyc_i   (wb_cyc),
        .wb_stb_i   (wb_stb),
        .wb_ack_o   (wb_ack),
        .wb_dat_o   (wb_dat_o),
        .fault_i    (fault),
        .ramp_o     (ramp),
`ifdef QCW_RAMP_IRQ_EN
        .irq_o      (irq),
`endif
        .drive_en_o (drive_en)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // One Wishbone access; checks a single-cycle ack and idle read data.
    task automatic wb_acc(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic w, output logic [31:0] rd);
        int t;
        @(negedge clk);
        wb_adr = a; wb_dat = d; wb_sel = s; wb_we = w; wb_cyc = 1'b1; wb_stb = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!wb_ack && t < 8);
        chk("ack_seen", {31'd0, wb_ack}, 32'd1);
        rd = wb_dat_o;
        wb_cyc = 1'b0; wb_stb = 1'b0; wb_we = 1'b0;
        @(negedge clk);
        chk("ack_len", {31'd0, wb_ack}, 32'd0);
        chk("dat_idle", wb_dat_o, 32'd0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] dummy;
        wb_acc(a, d, s, 1'b1, dummy);
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        wb_acc(a, 32'h0, 4'hF, 1'b0, v);
        chk(tag, v, exp);
    endtask

    task automatic push(input logic en, input logic [11:0] l);
        sb.push_back({en, l});
    endtask

    // Waits for drive enable, then pops and compares one sample per cycle.
    // fault_idx / rst_idx pulse fault_i or the reset for one cycle after
    // the sample with that index.
    task automatic mon(input int fault_idx, input int rst_idx);
        int t;
        logic [12:0] e;
        t = 0;
        while (drive_en !== 1'b1 && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("drv_rise", {31'd0, drive_en}, 32'd1);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk("envelope", {19'd0, drive_en, ramp}, {19'd0, e});
            fault = (t >= 0) && (fault_idx == 0);
            rst_n = !(rst_idx == 0);
            fault_idx--;
            rst_idx--;
            @(negedge clk);
        end
        fault = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic push_nominal(input int n_hold, input int n_zero);
        for (int l = 10; l <= 13; l++) begin
            push(1'b1, 12'(l));
            push(1'b1, 12'(l));
        end
        for (int i = 0; i < n_hold; i++) push(1'b1, 12'd13);
        for (int i = 0; i < n_zero; i++) push(1'b0, 12'd0);
    endtask

    task automatic cfg_nominal();
        wr(A_STRT, 32'd10, 4'hF);
        wr(A_END,  32'd13, 4'hF);
        wr(A_STEP, 32'd1,  4'hF);
        wr(A_HOLD, 32'd4,  4'hF);
        wr(A_COOL, 32'd2,  4'hF);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ack", {31'd0, wb_ack}, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_out", {19'd0, drive_en, ramp}, 32'd0);
        rst_n = 1'b1;
        rd("rst_ctrl", A_CTRL, 32'd0);
        rd("rst_lvl", A_LVL, 32'd0);

        // Bus handshake and byte lanes
        wr(A_STEP, 32'h1234, 4'hF);
        rd("step_rb", A_STEP, 32'h1234);
        rd("unmapped", BASE + 32'h1C, 32'd0);
        wr(A_STRT, 32'hABC, 4'b0001);
        rd("sel_lane", A_STRT, 32'hBC);
        @(negedge clk);
        wb_adr = BASE + 32'h20; wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0;
        repeat (3) @(negedge clk);
        chk("out_window", {31'd0, wb_ack}, 32'd0);
        wb_cyc = 1'b0; wb_stb = 1'b0;
        wr(A_CTRL, 32'h100, 4'b0010);
        rd("irq_en_bit", A_CTRL, c_irq_bit);
        wr(A_CTRL, 32'h0, 4'b0010);

        // Nominal run
        cfg_nominal();
        push_nominal(5, 5);
        fork
            wr(A_CTRL, 32'd1, 4'hF);
            mon(-1, -1);
        join
        rd("nom_done", A_CTRL, 32'h8);
        rd("nom_lvl", A_LVL, 32'd13);
        wr(A_CTRL, 32'h8, 4'hF);
        rd("done_clr", A_CTRL, 32'd0);

        // Degenerate levels, plus a START issued during COOL
        wr(A_STRT, 32'd20, 4'hF);
        wr(A_END,  32'd5,  4'hF);
        wr(A_STEP, 32'd0,  4'hF);
        wr(A_HOLD, 32'd0,  4'hF);
        wr(A_COOL, 32'd10, 4'hF);
        push(1'b1, 12'd20);
        push(1'b1, 12'd20);
        for (int i = 0; i < 17; i++) push(1'b0, 12'd0);
        fork
            begin
                wr(A_CTRL, 32'd1, 4'hF);
                rd("deg_busy", A_CTRL, 32'h4);
                wr(A_CTRL, 32'd1, 4'hF);
            end
            mon(-1, -1);
        join
        rd("deg_done", A_CTRL, 32'h8);
        wr(A_CTRL, 32'h8, 4'hF);

        // Fault mid-RAMP at level 11
        cfg_nominal();
        push(1'b1, 12'd10);
        push(1'b1, 12'd10);
        push(1'b1, 12'd11);
        for (int i = 0; i < 5; i++) push(1'b0, 12'd0);
        fork
            wr(A_CTRL, 32'd1, 4'hF);
            mon(2, -1);
        join
        rd("flt_flags", A_CTRL, 32'h18);
        wr(A_CTRL, 32'h18, 4'hF);
        rd("flt_clr", A_CTRL, 32'd0);

        // Reset during HOLD
        push_nominal(2, 0);
        for (int i = 0; i < 4; i++) push(1'b0, 12'd0);
        fork
            wr(A_CTRL, 32'd1, 4'hF);
            mon(-1, 9);
        join
        rd("rr_ctrl", A_CTRL, 32'd0);
        rd("rr_strt", A_STRT, 32'd0);
        rd("rr_end",  A_END,  32'd0);
        rd("rr_step", A_STEP, 32'd0);
        rd("rr_hold", A_HOLD, 32'd0);
        rd("rr_cool", A_COOL, 32'd0);
        rd("rr_lvl",  A_LVL,  32'd0);

`ifdef QCW_RAMP_IRQ_EN
        cfg_nominal();
        wr(A_CTRL, 32'h100, 4'b0010);
        wr(A_CTRL, 32'h1, 4'b0001);
        repeat (25) @(negedge clk);
        chk("irq_high", {31'd0, irq}, 32'd1);
        rd("irq_ctrl", A_CTRL, 32'h108);
        wr(A_CTRL, 32'h8, 4'b0001);
        @(negedge clk);
        chk("irq_low", {31'd0, irq}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
